// File: rtl/wrapper_sched_pkg.sv
// Shared types and widths for the wrapper engine scheduler.
package wrapper_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAIL  = 3'd4
  } state_t;

  localparam int UI_W = 2;
  localparam int V_W  = 16;
  localparam int WD_W = 21;

endpackage

// File: rtl/wrapper_sched_rr_arbiter.sv
// Round-robin priority rotation: grants the first set request after 'last', wrapping.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [IDW-1:0] gnt_id,
  output logic           any
);

  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!any && req[(int'(last) + i) % N]) begin
        any    = 1'b1;
        gnt_id = IDW'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/wrapper_sched.sv
// Shares one wrapper engine between N requesters: round-robin grant, operand latch,
// start pulse, tagged write forwarding and done/timeout reporting.
module wrapper_sched
  import wrapper_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [UI_W*N-1:0]   req_ui,
  input  logic [V_W*N-1:0]    req_v,
  output logic [N-1:0]        ack,
  output logic [N-1:0]        done,
  output logic [N-1:0]        err,
  output logic                busy,
  output logic                eng_start,
  output logic [UI_W-1:0]     eng_ui,
  output logic [V_W-1:0]      eng_v,
  input  logic                eng_done,
  input  logic                eng_wr_req,
  input  logic [WD_W-1:0]     eng_wr_data,
  output logic                out_valid,
  output logic [WD_W-1:0]     out_data,
  output logic [IDW-1:0]      out_id
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [IDW-1:0]    cur_q, cur_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      ack_q, ack_d;
  logic [N-1:0]      done_q, done_d;
  logic [N-1:0]      err_q, err_d;
  logic              busy_q, busy_d;
  logic              eng_start_q, eng_start_d;
  logic [UI_W-1:0]   eng_ui_q, eng_ui_d;
  logic [V_W-1:0]    eng_v_q, eng_v_d;
  logic              out_valid_q, out_valid_d;
  logic [WD_W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0]    out_id_q, out_id_d;

  logic [IDW-1:0]    gnt_id;
  logic              gnt_any;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req    (req),
    .last   (last_q),
    .gnt_id (gnt_id),
    .any    (gnt_any)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    done_d      = '0;
    err_d       = '0;
    eng_start_d = 1'b0;
    eng_ui_d    = eng_ui_q;
    eng_v_d     = eng_v_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          cur_d         = gnt_id;
          eng_ui_d      = req_ui[gnt_id*UI_W +: UI_W];
          eng_v_d       = req_v[gnt_id*V_W +: V_W];
          ack_d[gnt_id] = 1'b1;
          state_d       = START;
        end
      end
      START: begin
        eng_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = RUN;
      end
      RUN: begin
        cnt_d       = cnt_q + 1'b1;
        out_valid_d = eng_wr_req;
        out_data_d  = eng_wr_data;
        out_id_d    = cur_q;
        // Completion wins over a timeout landing in the same cycle.
        if (eng_done) begin
          done_d[cur_q] = 1'b1;
          state_d       = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d[cur_q] = 1'b1;
          state_d      = FAIL;
        end
      end
      DONE, FAIL: begin
        last_d  = cur_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      last_q      <= IDW'(N - 1);
      cnt_q       <= '0;
      ack_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      eng_start_q <= 1'b0;
      eng_ui_q    <= '0;
      eng_v_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      eng_start_q <= eng_start_d;
      eng_ui_q    <= eng_ui_d;
      eng_v_q     <= eng_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign eng_start = eng_start_q;
  assign eng_ui    = eng_ui_q;
  assign eng_v     = eng_v_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
